// File: rtl/video_dither_out.sv
// Output stage behind the layered video source: realigns timing to the registered colour,
// ordered-dithers COLSPC-bit colour down to OUTSPC bits and gates DE until frame lock is held.
module video_dither_out #(
    parameter int COORDSPC  = 16,
    parameter int COLSPC    = 10,
    parameter int OUTSPC    = 8,
    parameter int SRC_LAT   = 1,
    parameter int MAX_LINES = 2048
) (
    input  logic                       video_clk_pix,
    input  logic                       video_rst_n,
    input  logic                       video_enable,
    input  logic                       hsync,
    input  logic                       vsync,
    input  logic                       frame_start,
    input  logic                       line_start,
    input  logic signed [COORDSPC-1:0] sx,
    input  logic signed [COORDSPC-1:0] sy,
    input  logic        [COLSPC-1:0]   red,
    input  logic        [COLSPC-1:0]   green,
    input  logic        [COLSPC-1:0]   blue,
    input  logic                       dither_en,
    output logic        [OUTSPC-1:0]   out_red,
    output logic        [OUTSPC-1:0]   out_green,
    output logic        [OUTSPC-1:0]   out_blue,
    output logic                       out_hsync,
    output logic                       out_vsync,
    output logic                       out_de,
    output logic                       out_sof,
    output logic                       locked,
    output logic                       sync_err
);

    localparam int DROP = COLSPC - OUTSPC;
    localparam int LCW  = $clog2(MAX_LINES + 1);
    localparam int TW   = 9;
    localparam logic [LCW-1:0] LAST_LINE = LCW'(MAX_LINES - 1);

    // Standard 4x4 Bayer thresholds, indexed by {y, x}.
    localparam logic [15:0][3:0] BAYER = {
        4'd5, 4'd13, 4'd7, 4'd15,
        4'd9, 4'd1,  4'd11, 4'd3,
        4'd6, 4'd14, 4'd4, 4'd12,
        4'd10, 4'd2, 4'd8, 4'd0
    };

    generate
        if (DROP < 0 || DROP > 4) begin : g_bad_drop
            $error("video_dither_out: COLSPC-OUTSPC must be in 0..4");
        end
    endgenerate

    typedef enum logic {S_WAIT, S_RUN} state_t;

    state_t          state, state_n;
    logic [1:0]      frame_cnt, frame_n;
    logic [LCW-1:0]  line_cnt, line_n;
    logic            pix_on, lock_lost;

    logic [TW-1:0]   tap_in, tap_out;
    logic            a_en, a_hs, a_vs, a_fs, a_ls;
    logic [1:0]      a_sx, a_sy;
    logic            unused_coord_bits;

    assign tap_in = {video_enable, hsync, vsync, frame_start, line_start, sx[1:0], sy[1:0]};
    assign unused_coord_bits = ^{sx[COORDSPC-1:2], sy[COORDSPC-1:2]};

    generate
        if (SRC_LAT == 0) begin : g_no_dly
            assign tap_out = tap_in;
        end else begin : g_dly
            logic [SRC_LAT-1:0][TW-1:0] taps;
            // NOTE: the delay taps are only SRC_LAT words deep, so they are reset
            // outright; this keeps syncs and frame_start clean straight after reset.
            always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
                if (!video_rst_n) begin
                    taps <= '0;
                end else begin
                    taps[0] <= tap_in;
                    for (int i = 1; i < SRC_LAT; i++) taps[i] <= taps[i-1];
                end
            end
            assign tap_out = taps[SRC_LAT-1];
        end
    endgenerate

    assign {a_en, a_hs, a_vs, a_fs, a_ls, a_sx, a_sy} = tap_out;

    function automatic logic [OUTSPC-1:0] dither_chan(input logic [COLSPC-1:0] c,
                                                      input logic [3:0]        t,
                                                      input logic              en);
        logic [COLSPC+3:0] ext;
        logic [OUTSPC-1:0] q;
        // Low 4 bits of the shifted value are the dropped fraction scaled to 4 bits.
        ext = {c, 4'b0000} >> DROP;
        q   = OUTSPC'(c >> DROP);
        if (en && (ext[3:0] > t) && (q != '1)) return q + 1'b1;
        return q;
    endfunction

    logic [1:0] bx, by;
    logic [3:0] thr;
    assign bx  = a_sx + frame_cnt;
    assign by  = a_sy + frame_cnt;
    assign thr = BAYER[{by, bx}];

    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            state     <= S_WAIT;
            frame_cnt <= '0;
            line_cnt  <= '0;
        end else begin
            state     <= state_n;
            frame_cnt <= frame_n;
            line_cnt  <= line_n;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_n   = state;
        frame_n   = frame_cnt;
        line_n    = line_cnt;
        pix_on    = 1'b0;
        lock_lost = 1'b0;
        case (state)
            S_WAIT: begin
                if (a_fs) begin
                    state_n = S_RUN;
                    frame_n = '0;
                    line_n  = '0;
                    pix_on  = 1'b1;
                end
            end
            S_RUN: begin
                pix_on = 1'b1;
                if (a_fs) begin
                    frame_n = frame_cnt + 2'd1;
                    line_n  = '0;
                end else if (a_ls) begin
                    if (line_cnt == LAST_LINE) begin
                        state_n   = S_WAIT;
                        lock_lost = 1'b1;
                        pix_on    = 1'b0;
                    end else begin
                        line_n = line_cnt + 1'b1;
                    end
                end
            end
            default: state_n = S_WAIT;
        endcase
    end

    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            out_red   <= '0;
            out_green <= '0;
            out_blue  <= '0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_de    <= 1'b0;
            out_sof   <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            out_hsync <= a_hs;
            out_vsync <= a_vs;
            out_de    <= pix_on & a_en;
            out_sof   <= pix_on & a_fs;
            sync_err  <= lock_lost;
            if (pix_on && a_en) begin
                out_red   <= dither_chan(red,   thr, dither_en);
                out_green <= dither_chan(green, thr, dither_en);
                out_blue  <= dither_chan(blue,  thr, dither_en);
            end else begin
                out_red   <= '0;
                out_green <= '0;
                out_blue  <= '0;
            end
        end
    end

    assign locked = (state == S_RUN);

endmodule

// File: tb/tb_video_dither_out.sv
// Scoreboard bench for video_dither_out: the driver queues hand-computed expectations tagged
// with the cycle they must appear on; a negedge monitor pops and compares them.
module tb_video_dither_out;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        video_enable = 1'b0, hsync = 1'b0, vsync = 1'b0;
    logic        frame_start = 1'b0, line_start = 1'b0, dither_en = 1'b0;
    logic [15:0] sx = '0, sy = '0;
    logic [9:0]  red = '0, green = '0, blue = '0;
    logic [7:0]  out_red, out_green, out_blue;
    logic        out_hsync, out_vsync, out_de, out_sof, locked, sync_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int pix_n = 0;

    typedef struct {
        int         tgt;
        logic       de, sof, hs, vs, lk, er;
        logic [7:0] r, g, b;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [9:0] pend_r = '0, pend_g = '0, pend_b = '0;
    logic       pend_d = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    video_dither_out #(.MAX_LINES(4)) dut (
        .video_clk_pix(clk),
        .video_rst_n  (rst_n),
        .video_enable (video_enable),
        .hsync        (hsync),
        .vsync        (vsync),
        .frame_start  (frame_start),
        .line_start   (line_start),
        .sx           (sx),
        .sy           (sy),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .dither_en    (dither_en),
        .out_red      (out_red),
        .out_green    (out_green),
        .out_blue     (out_blue),
        .out_hsync    (out_hsync),
        .out_vsync    (out_vsync),
        .out_de       (out_de),
        .out_sof      (out_sof),
        .locked       (locked),
        .sync_err     (sync_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // One pixel: timing now, its colour/dither_en one cycle later, output two cycles later.
    task automatic px(input logic en, input logic fs, input logic ls,
                      input logic [15:0] x, input logic [15:0] y,
                      input logic [9:0] cr, input logic [9:0] cg, input logic [9:0] cb,
                      input logic d,
                      input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                      input logic ede, input logic esof, input logic elk, input logic eerr);
        exp_t       e;
        logic [7:0] pn;
        @(posedge clk);
        #1;
        pn           = 8'(pix_n);
        video_enable = en;
        hsync        = pn[0];
        vsync        = pn[3];
        frame_start  = fs;
        line_start   = ls;
        sx           = x;
        sy           = y;
        red          = pend_r;
        green        = pend_g;
        blue         = pend_b;
        dither_en    = pend_d;
        pend_r       = cr;
        pend_g       = cg;
        pend_b       = cb;
        pend_d       = d;
        e.tgt = cyc + 2;
        e.de  = ede;
        e.sof = esof;
        e.hs  = pn[0];
        e.vs  = pn[3];
        e.lk  = elk;
        e.er  = eerr;
        e.r   = er;
        e.g   = eg;
        e.b   = eb;
        sb.push_back(e);
        pix_n++;
    endtask

    task automatic pxs(input logic en, input logic fs, input logic ls,
                       input logic [15:0] x, input logic [15:0] y,
                       input logic [9:0] c, input logic d, input logic [7:0] ec,
                       input logic ede, input logic esof, input logic elk, input logic eerr);
        px(en, fs, ls, x, y, c, c, c, d, ec, ec, ec, ede, esof, elk, eerr);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        video_enable = 1'b0;
        hsync        = 1'b0;
        vsync        = 1'b0;
        frame_start  = 1'b0;
        line_start   = 1'b0;
        red          = pend_r;
        green        = pend_g;
        blue         = pend_b;
        dither_en    = pend_d;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tgt <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.tgt != cyc) begin
                check("sched", cyc, mon_e.tgt);
            end else begin
                check("de",     out_de,    mon_e.de);
                check("sof",    out_sof,   mon_e.sof);
                check("hsync",  out_hsync, mon_e.hs);
                check("vsync",  out_vsync, mon_e.vs);
                check("locked", locked,    mon_e.lk);
                check("serr",   sync_err,  mon_e.er);
                check("red",    out_red,   mon_e.r);
                check("green",  out_green, mon_e.g);
                check("blue",   out_blue,  mon_e.b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        logic [7:0] ev;

        // Reset state, with live timing inputs that must not leak through.
        hsync        = 1'b1;
        video_enable = 1'b1;
        frame_start  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_de",   out_de,    1'b0);
        check("rst_sof",  out_sof,   1'b0);
        check("rst_hs",   out_hsync, 1'b0);
        check("rst_lock", locked,    1'b0);
        check("rst_serr", sync_err,  1'b0);
        check("rst_red",  out_red,   8'h00);
        video_enable = 1'b0;
        frame_start  = 1'b0;
        hsync        = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Mid-frame after reset: active video but no frame_start, so DE and colour stay 0.
        for (int i = 0; i < 4; i++)
            pxs(1'b1, 1'b0, (i == 0), 16'(i), 16'd5, 10'h3FF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Lock and latency: frame_start pixel with colour 3FC comes out as FF with SOF.
        pxs(1'b1, 1'b1, 1'b1, 16'hFFFE, 16'h0007, 10'h3FC, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);

        // Dither, frame count 0, c=101: 41 where Bayer threshold < 4.
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                ev = ((x % 2 == 0) && (y % 2 == 0)) ? 8'h41 : 8'h40;
                pxs(1'b1, 1'b0, (x == 0 && y > 0), 16'(x - 4), 16'(y + 8), 10'h101, 1'b1, ev,
                    1'b1, 1'b0, 1'b1, 1'b0);
            end
        end

        // Rotation over four frames (counts 1,2,3,0); the frame_start pixel is blanking.
        for (int k = 1; k <= 4; k++) begin
            f = k % 4;
            pxs(1'b0, 1'b1, 1'b1, 16'd0, 16'd0, 10'h101, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
            for (int y = 0; y < 2; y++) begin
                for (int x = 0; x < 4; x++) begin
                    ev = (((x + f) % 2 == 0) && ((y + f) % 2 == 0)) ? 8'h41 : 8'h40;
                    pxs(1'b1, 1'b0, (x == 0 && y == 1), 16'(x), 16'(y), 10'h101, 1'b1, ev,
                        1'b1, 1'b0, 1'b1, 1'b0);
                end
            end
        end

        // Saturation with dither on at every position.
        for (int i = 0; i < 16; i++)
            pxs(1'b1, 1'b0, 1'b0, 16'(i % 4), 16'(i / 4), 10'h3FF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        // Independent channels with dither on at (0,0): 101->41, 3FE->FF (saturated), 0FF->40.
        px(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 10'h101, 10'h3FE, 10'h0FF, 1'b1,
           8'h41, 8'hFF, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0);
        // Dither disabled: plain truncation.
        pxs(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 10'h3FF, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        pxs(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 10'h103, 1'b0, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0);
        px(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 10'h104, 10'h208, 10'h30C, 1'b0,
           8'h41, 8'h82, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0);
        // Blanking inside RUN: colour forced to 0.
        pxs(1'b0, 1'b0, 1'b0, 16'd1, 16'd0, 10'h3FF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Line timeout with MAX_LINES=4: the fourth line_start drops lock.
        pxs(1'b1, 1'b1, 1'b1, 16'd0, 16'd0, 10'h3FC, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int y = 1; y < 4; y++)
            pxs(1'b1, 1'b0, 1'b1, 16'd0, 16'(y), 10'h3FC, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        pxs(1'b1, 1'b0, 1'b1, 16'd0, 16'd4, 10'h3FC, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        pxs(1'b1, 1'b0, 1'b0, 16'd1, 16'd4, 10'h3FC, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        // Next frame_start relocks.
        pxs(1'b1, 1'b1, 1'b1, 16'd0, 16'd0, 10'h3FC, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
        pxs(1'b1, 1'b0, 1'b0, 16'd1, 16'd0, 10'h3FC, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);

        repeat (3) idle();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        check("drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
